// File: rtl/sprite_pkg.sv
// sprite_pkg: shared FSM state type, pixel format codes, RGBA8888 field
// offsets and colour-channel expansion helpers for the sprite fetcher.
package sprite_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    localparam int FMT_RGBA5551 = 0;
    localparam int FMT_RGB565   = 1;
    localparam int R_OFF = 24;
    localparam int G_OFF = 16;
    localparam int B_OFF = 8;
    localparam int A_OFF = 0;
    function automatic logic [7:0] exp5(input logic [4:0] x);
        return {x, x[4:2]};
    endfunction
    function automatic logic [7:0] exp6(input logic [5:0] x);
        return {x, x[5:4]};
    endfunction
endpackage

// File: rtl/rgb_expand.sv
// rgb_expand: combinational unpack of a 16-bit SRAM word into RGBA8888.
// Ports:
//   pix   in  16  raw pixel word (RGBA5551 or RGB565 depending on FMT)
//   rgba  out 32  expanded pixel, R in the top byte, A in the bottom byte
module rgb_expand import sprite_pkg::*; #(
    parameter int FMT = FMT_RGBA5551
) (
    input  logic [15:0] pix,
    output logic [31:0] rgba
);
    logic [7:0] r, g, b, a;
    always_comb begin
        r = exp5(pix[15:11]);
        g = (FMT == FMT_RGB565) ? exp6(pix[10:5]) : exp5(pix[10:6]);
        b = (FMT == FMT_RGB565) ? exp5(pix[4:0]) : exp5(pix[5:1]);
        a = (FMT == FMT_RGB565 || pix[0]) ? 8'hFF : 8'h00;
        rgba = (32'(r) << R_OFF) | (32'(g) << G_OFF) | (32'(b) << B_OFF) | (32'(a) << A_OFF);
    end
endmodule

// File: rtl/sprite_fetch.sv
// sprite_fetch: walks an IMG_W x IMG_H image in SRAM row by row, issuing one
// read per enabled cycle, and returns each pixel expanded to RGBA8888.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                frame start; latches i_base, i_bias, i_mirror (aborts a frame in flight)
//   i_en                   request the next pixel while running
//   i_base / i_bias        image base word address / signed rows skipped at the top
//   i_mirror               horizontal mirror
//   i_sram_rdata           SRAM read data, valid RD_LAT cycles after o_sram_oe
//   o_sram_addr, o_sram_oe SRAM read address and enable
//   o_q, o_valid           expanded pixel and its qualifier (o_q is 0 when not valid)
//   o_busy, o_done         frame in progress, one-cycle end-of-frame pulse
module sprite_fetch import sprite_pkg::*; #(
    parameter int IMG_W  = 200,
    parameter int IMG_H  = 200,
    parameter int ADDR_W = 20,
    parameter int BIAS_W = 13,
    parameter int RD_LAT = 1,
    parameter int FMT    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_en,
    input  logic [ADDR_W-1:0]        i_base,
    input  logic signed [BIAS_W-1:0] i_bias,
    input  logic                     i_mirror,
    input  logic [15:0]              i_sram_rdata,
    output logic [ADDR_W-1:0]        o_sram_addr,
    output logic                     o_sram_oe,
    output logic [31:0]              o_q,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);
    localparam logic signed [BIAS_W-1:0] H_B = BIAS_W'(IMG_H);
    localparam logic [1:0] D_LAST = 2'(RD_LAT - 1);

    state_t              state, state_n;
    logic [RW-1:0]       row, row_n, start_row;
    logic [CW-1:0]       col, col_n, col_m;
    logic [ADDR_W-1:0]   row_addr, row_addr_n, addr_n;
    logic                mirror, mirror_n, oe_n, done_n;
    logic [1:0]          cnt, cnt_n;
    logic [RD_LAT-1:0]   pipe, pipe_n;
    logic [RD_LAT:0]     shifted;
    logic                bias_pos, bias_over;
    logic [31:0]         pix;

    assign bias_pos  = !i_bias[BIAS_W-1] && (i_bias != '0);
    assign bias_over = i_bias >= H_B;
    assign start_row = (bias_pos && !bias_over) ? RW'(i_bias) : '0;
    assign col_m     = mirror ? LAST_C - col : col;
    // Valid pipeline: stage k holds the read enable issued k+1 cycles ago.
    assign shifted   = {pipe, o_sram_oe};

    always_comb begin
        state_n    = state;
        row_n      = row;
        col_n      = col;
        row_addr_n = row_addr;
        mirror_n   = mirror;
        addr_n     = o_sram_addr;
        oe_n       = 1'b0;
        done_n     = 1'b0;
        cnt_n      = cnt;
        pipe_n     = shifted[RD_LAT-1:0];
        if (i_start) begin
            // Start always wins: reads in flight are forgotten and no read is issued.
            pipe_n     = '0;
            row_n      = start_row;
            col_n      = '0;
            row_addr_n = i_base + ADDR_W'(start_row) * W_A;
            mirror_n   = i_mirror;
            cnt_n      = '0;
            state_n    = bias_over ? ST_DRAIN : ST_RUN;
        end else if (state == ST_RUN && i_en) begin
            oe_n   = 1'b1;
            addr_n = row_addr + ADDR_W'(col_m);
            col_n  = (col == LAST_C) ? '0 : col + 1'b1;
            if (col == LAST_C) begin
                row_n      = row + 1'b1;
                row_addr_n = row_addr + W_A;
            end
            if (col == LAST_C && row == LAST_R) begin
                state_n = ST_DRAIN;
                cnt_n   = '0;
            end
        end else if (state == ST_DRAIN) begin
            state_n = (cnt == D_LAST) ? ST_IDLE : ST_DRAIN;
            done_n  = (cnt == D_LAST);
            cnt_n   = cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            row         <= '0;
            col         <= '0;
            row_addr    <= '0;
            mirror      <= 1'b0;
            o_sram_addr <= '0;
            o_sram_oe   <= 1'b0;
            o_done      <= 1'b0;
            cnt         <= '0;
            pipe        <= '0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            col         <= col_n;
            row_addr    <= row_addr_n;
            mirror      <= mirror_n;
            o_sram_addr <= addr_n;
            o_sram_oe   <= oe_n;
            o_done      <= done_n;
            cnt         <= cnt_n;
            pipe        <= pipe_n;
        end
    end

    rgb_expand #(.FMT(FMT)) u_expand (
        .pix  (i_sram_rdata),
        .rgba (pix)
    );

    assign o_busy  = state != ST_IDLE;
    assign o_valid = pipe[RD_LAT-1];
    assign o_q     = o_valid ? pix : '0;
endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: scoreboard bench for sprite_fetch (4x3 image, 2-cycle SRAM).
module tb_sprite_fetch;
    localparam int W = 4, H = 3, AW = 20, BW = 13, LAT = 2;

    logic clk = 0, rst_n = 0, start = 0, en = 0, mirror = 0;
    logic [AW-1:0] base = '0;
    logic signed [BW-1:0] bias = '0;
    logic [15:0] rdata;
    logic [AW-1:0] addr, addr1, ad1, ad2;
    logic oe, oe1, valid, valid1, busy, busy1, done, done1, en_q;
    logic [31:0] q, q1;

    typedef struct {int due; logic [AW-1:0] a;} pend_t;
    logic [AW-1:0] aq[$];
    pend_t pq[$];
    int cyc = 0, checks = 0, failures = 0, done_cnt = 0, exp_done = -1;

    always #5 clk = ~clk;

    sprite_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BIAS_W(BW), .RD_LAT(LAT), .FMT(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_en(en), .i_base(base), .i_bias(bias),
        .i_mirror(mirror), .i_sram_rdata(rdata), .o_sram_addr(addr), .o_sram_oe(oe), .o_q(q),
        .o_valid(valid), .o_busy(busy), .o_done(done));

    sprite_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BIAS_W(BW), .RD_LAT(LAT), .FMT(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_en(en), .i_base(base), .i_bias(bias),
        .i_mirror(mirror), .i_sram_rdata(rdata), .o_sram_addr(addr1), .o_sram_oe(oe1), .o_q(q1),
        .o_valid(valid1), .o_busy(busy1), .o_done(done1));

    function automatic logic [15:0] sram_data(input logic [AW-1:0] a);
        case (a)
            20'd100: return 16'hF801;
            20'd101: return 16'h07C0;
            20'd102: return 16'hFFFF;
            20'd103: return 16'h0000;
            default: return 16'((a * 20'd40503) ^ 20'h01234);
        endcase
    endfunction
    function automatic logic [7:0] x5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction
    function automatic logic [7:0] x6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction
    function automatic logic [31:0] model0(input logic [15:0] d);
        return {x5(d[15:11]), x5(d[10:6]), x5(d[5:1]), {8{d[0]}}};
    endfunction
    function automatic logic [31:0] model1(input logic [15:0] d);
        return {x5(d[15:11]), x6(d[10:5]), x5(d[4:0]), 8'hFF};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // SRAM model with a two-cycle read latency.
    always @(posedge clk) begin
        ad1  <= addr;
        ad2  <= ad1;
        en_q <= en && !start;
    end
    assign rdata = sram_data(ad2);

    always @(negedge clk) begin : mon
        logic [AW-1:0] a;
        pend_t p;
        cyc++;
        if (rst_n) begin
            if (aq.size() > 0) check("oe", oe, en_q);
            if (oe) begin
                if (aq.size() == 0) check("read_extra", oe, 1'b0);
                else begin
                    a = aq.pop_front();
                    check("addr", addr, a);
                    pq.push_back('{cyc + LAT, a});
                    if (aq.size() == 0) exp_done = cyc + LAT;
                end
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                check("valid", valid, 1'b1);
                check("q_fmt0", q, model0(sram_data(p.a)));
                check("q_fmt1", q1, model1(sram_data(p.a)));
                case (p.a)
                    20'd100: check("q_f801", q, 32'hFF0000FF);
                    20'd101: check("q_07c0", q, 32'h00FF0000);
                    20'd102: check("q1_ffff", q1, 32'hFFFFFFFF);
                    20'd103: check("q1_0000", q1, 32'h000000FF);
                    default: ;
                endcase
            end else begin
                check("valid_idle", valid, 1'b0);
                check("q_zero", q, 32'h0);
            end
            if (done) begin
                done_cnt++;
                check("done_cyc", cyc, exp_done);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [AW-1:0] b, input int first_row, input logic m);
        for (int r = first_row; r < H; r++)
            for (int c = 0; c < W; c++)
                aq.push_back(b + AW'(r * W + (m ? W - 1 - c : c)));
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input int bi, input logic m);
        base = b;
        bias = BW'(bi);
        mirror = m;
        start = 1;
        en = 1;
        step();
        start = 0;
    endtask

    task automatic finish_frame(input int d0, input logic toggle);
        int n = 0;
        while (aq.size() > 0 && n < 100) begin
            en = toggle ? ~en : 1'b1;
            step();
            n++;
        end
        en = 0;
        check("reads_left", aq.size(), 0);
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            step();
            n++;
        end
        check("done_seen", done_cnt, d0 + 1);
        check("busy_after", busy, 1'b0);
        step();
        check("done_pulse", done, 1'b0);
        check("pending", pq.size(), 0);
        check("done_once", done_cnt, d0 + 1);
    endtask

    task automatic run_frame(input logic [AW-1:0] b, input int bi, input logic m, input logic toggle);
        int fr = (bi >= H) ? H : (bi > 0 ? bi : 0);
        int d0 = done_cnt;
        aq.delete();
        exp_done = -1;
        push_frame(b, fr, m);
        if (bi >= H) exp_done = cyc + 1 + LAT;
        pulse_start(b, bi, m);
        check("busy_run", busy, 1'b1);
        finish_frame(d0, toggle);
    endtask

    initial begin
        int n, d0, dropped;
        pend_t kept[$];
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr", addr, 0);
        check("rst_oe", oe, 0);
        check("rst_q", q, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1;
        step();

        run_frame(100, 0, 0, 0);
        run_frame(100, 2, 0, 0);
        run_frame(100, -5, 0, 0);
        run_frame(100, 3, 0, 0);
        run_frame(0, 0, 1, 0);
        run_frame(40, 0, 0, 1);

        // Abort after five reads: the two reads still in flight must vanish.
        aq.delete();
        exp_done = -1;
        d0 = done_cnt;
        push_frame(200, 0, 0);
        pulse_start(200, 0, 0);
        n = 0;
        while (aq.size() > 7 && n < 50) begin
            step();
            n++;
        end
        dropped = 0;
        kept.delete();
        foreach (pq[i])
            if (pq[i].due > cyc) dropped++;
            else kept.push_back(pq[i]);
        pq = kept;
        check("abort_inflight", dropped, 2);
        aq.delete();
        push_frame(300, 0, 0);
        base = 300;
        start = 1;
        step();
        start = 0;
        finish_frame(d0, 0);

        // Reset mid-frame: outputs clear at once and the frame never completes.
        aq.delete();
        exp_done = -1;
        d0 = done_cnt;
        push_frame(0, 0, 0);
        pulse_start(0, 0, 0);
        n = 0;
        while (aq.size() > 8 && n < 50) begin
            step();
            n++;
        end
        #2 rst_n = 0;
        #1;
        check("mid_rst_addr", addr, 0);
        check("mid_rst_oe", oe, 0);
        check("mid_rst_q", q, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        aq.delete();
        pq.delete();
        en = 0;
        step();
        step();
        rst_n = 1;
        repeat (8) step();
        check("no_done_after_rst", done_cnt, d0);
        check("idle_after_rst", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
